// File: rtl/conv_seq_if.sv
// Host handshake plus weight/pixel/MAC control bundle driven by conv_seq.
interface conv_seq_if;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic [3:0] wmem_raddr;
    logic       w_we;
    logic [3:0] w_widx;
    logic [3:0] w_sel;
    logic [8:0] pix_raddr;
    logic       mac_en;
    logic       mac_clr;
    logic       out_valid;
    logic [8:0] out_addr;

    modport master (
        input  start, stall,
        output busy, done, wmem_raddr, w_we, w_widx, w_sel,
               pix_raddr, mac_en, mac_clr, out_valid, out_addr
    );
    modport slave (
        output start, stall,
        input  busy, done, wmem_raddr, w_we, w_widx, w_sel,
               pix_raddr, mac_en, mac_clr, out_valid, out_addr
    );
endinterface

// File: rtl/conv_seq.sv
// K x K convolution pass sequencer: weight preload, then window/tap walk
// with a 3-stage address -> MAC -> result-flag pipeline.
module conv_seq #(
    parameter int K     = 3,
    parameter int OUT_W = 19,
    parameter int IN_W  = OUT_W + K - 1
) (
    input  logic       clk,
    input  logic       xrst,
    conv_seq_if.master bus
);
    localparam int         STAGES  = 1;
    localparam logic [3:0] TAP_MAX = 4'(K * K - 1);
    localparam logic [4:0] K_MAX   = 5'(K - 1);
    localparam logic [4:0] W_MAX   = 5'(OUT_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state;
    logic [4:0]      kx, ky, wx, wy;
    logic            fin, dcnt, clr_p0;
    logic [STAGES:0] vld_pipe, last_pipe;
    logic [8:0]      oaddr_p0, oaddr_p1;

    logic       tap_first, tap_last, win_last, frz, issue;
    logic [8:0] row, pix_nxt, oaddr_nxt;
    logic [3:0] wsel_nxt;

    always_comb begin
        tap_first = (kx == '0) && (ky == '0);
        tap_last  = (kx == K_MAX) && (ky == K_MAX);
        win_last  = (wx == W_MAX) && (wy == W_MAX);
        frz       = bus.stall && (state == S_RUN || state == S_DRAIN);
        // first tap goes out on the LOAD->RUN edge so RUN cycle 1 carries it
        issue     = (state == S_LOAD && bus.wmem_raddr == TAP_MAX) ||
                    (state == S_RUN && !bus.stall && !fin);
        row       = 9'(wy) + 9'(ky);
        pix_nxt   = row * 9'(IN_W) + 9'(wx) + 9'(kx);
        wsel_nxt  = 4'(ky) * 4'(K) + 4'(kx);
        oaddr_nxt = 9'(wy) * 9'(OUT_W) + 9'(wx);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state          <= S_IDLE;
            kx             <= '0;
            ky             <= '0;
            wx             <= '0;
            wy             <= '0;
            fin            <= 1'b0;
            dcnt           <= 1'b0;
            clr_p0         <= 1'b0;
            vld_pipe       <= '0;
            last_pipe      <= '0;
            oaddr_p0       <= '0;
            oaddr_p1       <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.wmem_raddr <= '0;
            bus.w_we       <= 1'b0;
            bus.w_widx     <= '0;
            bus.w_sel      <= '0;
            bus.pix_raddr  <= '0;
            bus.mac_en     <= 1'b0;
            bus.mac_clr    <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_addr   <= '0;
        end else begin
            // weight memory has one cycle of latency
            bus.w_we   <= (state == S_LOAD);
            bus.w_widx <= (state == S_LOAD) ? bus.wmem_raddr : '0;

            case (state)
                S_IDLE: if (bus.start) begin
                    state          <= S_LOAD;
                    bus.busy       <= 1'b1;
                    bus.wmem_raddr <= '0;
                    kx             <= '0;
                    ky             <= '0;
                    wx             <= '0;
                    wy             <= '0;
                    fin            <= 1'b0;
                    dcnt           <= 1'b0;
                end
                S_LOAD: begin
                    if (bus.wmem_raddr == TAP_MAX) begin
                        state          <= S_RUN;
                        bus.wmem_raddr <= '0;
                    end else begin
                        bus.wmem_raddr <= bus.wmem_raddr + 4'd1;
                    end
                end
                S_RUN: if (!bus.stall && fin) state <= S_DRAIN;
                S_DRAIN: if (!bus.stall) begin
                    if (dcnt) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end
                    dcnt <= 1'b1;
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                bus.pix_raddr <= pix_nxt;
                bus.w_sel     <= wsel_nxt;
                oaddr_p0      <= oaddr_nxt;
                clr_p0        <= tap_first;
                fin           <= tap_last && win_last;
                // kx fastest, then ky, X, Y; everything parks at the final tap
                if (!(tap_last && win_last)) begin
                    if (kx != K_MAX) kx <= kx + 5'd1;
                    else begin
                        kx <= '0;
                        if (ky != K_MAX) ky <= ky + 5'd1;
                        else begin
                            ky <= '0;
                            if (wx != W_MAX) wx <= wx + 5'd1;
                            else begin
                                wx <= '0;
                                wy <= wy + 5'd1;
                            end
                        end
                    end
                end
            end

            if (frz) begin
                bus.mac_en    <= 1'b0;
                bus.mac_clr   <= 1'b0;
                bus.out_valid <= 1'b0;
            end else begin
                vld_pipe      <= {vld_pipe[0], issue};
                last_pipe     <= {last_pipe[0], issue && tap_last};
                oaddr_p1      <= oaddr_p0;
                bus.mac_en    <= vld_pipe[0];
                bus.mac_clr   <= vld_pipe[0] && clr_p0;
                bus.out_valid <= vld_pipe[1] && last_pipe[1];
                if (vld_pipe[1] && last_pipe[1]) bus.out_addr <= oaddr_p1;
            end

            if (state == S_DONE) begin
                bus.pix_raddr <= '0;
                bus.w_sel     <= '0;
                bus.out_addr  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conv_seq.sv
// Directed bench for conv_seq: full pass, stalled pass, mid-pass reset and restart.
module tb_conv_seq;
    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    conv_seq_if bus();
    conv_seq u_dut (.clk(clk), .xrst(xrst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cur_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s c=%0d obs=%0d exp=%0d", tag, cur_c, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_raddr"}, 32'(bus.wmem_raddr), 32'd0);
        chk({tag, "_we"},    32'(bus.w_we), 32'd0);
        chk({tag, "_wsel"},  32'(bus.w_sel), 32'd0);
        chk({tag, "_pix"},   32'(bus.pix_raddr), 32'd0);
        chk({tag, "_mac"},   32'(bus.mac_en), 32'd0);
        chk({tag, "_clr"},   32'(bus.mac_clr), 32'd0);
        chk({tag, "_ov"},    32'(bus.out_valid), 32'd0);
        chk({tag, "_oaddr"}, 32'(bus.out_addr), 32'd0);
    endtask

    // mode 0: unstalled pass with start pokes; mode 1: 5-cycle stall at edges 30..34
    task automatic run_pass(input int mode);
        int d, done_c, ovs, dones, macs;
        logic [8:0] tbl [9];
        tbl = '{9'd1, 9'd2, 9'd3, 9'd22, 9'd23, 9'd24, 9'd43, 9'd44, 9'd45};
        d      = (mode == 1) ? 5 : 0;
        done_c = 3260 + d;
        ovs = 0; dones = 0; macs = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int c = 0; c <= done_c + 5; c++) begin
            if (c > 0) @(negedge clk);
            cur_c = c;
            chk("busy", 32'(bus.busy), 32'(c <= done_c));
            chk("done", 32'(bus.done), 32'(c == done_c));
            if (bus.done) dones++;
            if (bus.mac_en) macs++;
            if (bus.out_valid) begin
                chk("oaddr_seq", 32'(bus.out_addr), 32'(ovs));
                ovs++;
            end
            if (mode == 0) begin
                chk("ov_time", 32'(bus.out_valid),
                    32'(c >= 19 && c <= 3259 && (c - 19) % 9 == 0));
                if (c <= 8) chk("wmem_raddr", 32'(bus.wmem_raddr), 32'(c));
                if (c >= 1 && c <= 9) begin
                    chk("w_we", 32'(bus.w_we), 32'd1);
                    chk("w_widx", 32'(bus.w_widx), 32'(c - 1));
                end
                if (c == 0 || c == 10) chk("w_we_off", 32'(bus.w_we), 32'd0);
                if (c >= 18 && c <= 26) begin
                    chk("pix_win1", 32'(bus.pix_raddr), 32'(tbl[c - 18]));
                    chk("wsel_win1", 32'(bus.w_sel), 32'(c - 18));
                end
                if (c >= 19 && c <= 27) begin
                    chk("mac_en_win1", 32'(bus.mac_en), 32'd1);
                    chk("mac_clr_win1", 32'(bus.mac_clr), 32'(c == 19));
                end
                if (c == 3257) begin
                    chk("pix_last", 32'(bus.pix_raddr), 32'd440);
                    chk("wsel_last", 32'(bus.w_sel), 32'd8);
                end
                if (c == 3258) chk("mac_last", 32'(bus.mac_en), 32'd1);
                if (c == 3259) begin
                    chk("mac_drain", 32'(bus.mac_en), 32'd0);
                    chk("ov_last", 32'(bus.out_valid), 32'd1);
                    chk("oaddr_last", 32'(bus.out_addr), 32'd360);
                end
            end else begin
                if (c >= 29 && c <= 34) begin
                    chk("pix_hold", 32'(bus.pix_raddr), 32'd4);
                    chk("wsel_hold", 32'(bus.w_sel), 32'd2);
                end
                if (c == 29) chk("mac_pre", 32'(bus.mac_en), 32'd1);
                if (c >= 30 && c <= 34) begin
                    chk("mac_stall", 32'(bus.mac_en), 32'd0);
                    chk("clr_stall", 32'(bus.mac_clr), 32'd0);
                    chk("ov_stall", 32'(bus.out_valid), 32'd0);
                end
                if (c == 35) begin
                    chk("mac_resume", 32'(bus.mac_en), 32'd1);
                    chk("clr_resume", 32'(bus.mac_clr), 32'd0);
                    chk("pix_resume", 32'(bus.pix_raddr), 32'd23);
                    chk("wsel_resume", 32'(bus.w_sel), 32'd3);
                end
                if (c == 37) chk("ov_shift_old", 32'(bus.out_valid), 32'd0);
                if (c == 42) begin
                    chk("ov_shift_new", 32'(bus.out_valid), 32'd1);
                    chk("oaddr_shift", 32'(bus.out_addr), 32'd2);
                end
            end
            bus.stall = (mode == 1) && (c + 1 >= 30) && (c + 1 < 35);
            bus.start = (mode == 0) && (c == 50 || c == done_c);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("pass_dones", 32'(dones), 32'd1);
        chk("pass_ovs", 32'(ovs), 32'd361);
        chk("pass_macs", 32'(macs), 32'd3249);
    endtask

    initial begin
        xrst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        xrst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("idle");

        run_pass(0);
        run_pass(1);

        // reset in the middle of RUN, then a fresh pass
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (200) @(negedge clk);
        cur_c = 200;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        xrst = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk); xrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cur_c = i;
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
            chk("post_rst_done", 32'(bus.done), 32'd0);
        end
        run_pass(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
